// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared constants, FSM state type and byte-count helper for the S2MM path
package dma_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam int BYTES_PER_BEAT = 4;
   localparam int BOUNDARY_4K    = 4096;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_ADDR,
      S_DATA,
      S_RESP,
      S_DONE
   } s2mm_state_t;

   function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
      keep_bytes = 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
   endfunction

endpackage

// File: rtl/s2mm_if.sv
// rtl/s2mm_if.sv - stream-in and AXI write-channel bundles used by the S2MM engine
interface axis_if;
   logic [31:0] tdata;
   logic [3:0]  tkeep;
   logic        tvalid;
   logic        tready;
   logic        tlast;

   modport master (output tdata, tkeep, tvalid, tlast, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

interface axi_wr_if;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic        wlast;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (output awaddr, awlen, awvalid, wdata, wstrb, wvalid, wlast, bready,
                   input  awready, wready, bresp, bvalid);
   modport slave  (input  awaddr, awlen, awvalid, wdata, wstrb, wvalid, wlast, bready,
                   output awready, wready, bresp, bvalid);
endinterface

// File: rtl/s2mm_fifo.sv
// rtl/s2mm_fifo.sv - synchronous first-word-fall-through beat buffer
module s2mm_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push && (count_q != (AW+1)'(DEPTH));
      do_pop   = pop && (count_q != '0);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage array carries no reset; validity is tracked by count_q
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

   assign rdata = mem[rd_ptr_q];
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/s2mm_top.sv
// rtl/s2mm_top.sv - S2MM engine: buffers one stream packet per command and writes it as 4 KB-safe INCR bursts
module s2mm_top
   import dma_pkg::*;
#(
   parameter int MAX_BURST  = 16,
   parameter int FIFO_DEPTH = 32,
   parameter int LEN_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_addr,
   input  logic [LEN_W-1:0] cmd_max_bytes,
   output logic             sts_valid,
   output logic [LEN_W-1:0] sts_bytes,
   output logic             sts_trunc,
   output logic             sts_error,
   axis_if.slave            s_axis,
   axi_wr_if.master         m_axi
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   s2mm_state_t      state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [LEN_W-1:0] max_q, max_d;
   logic [LEN_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0] bytes_q, bytes_d;
   logic             trunc_q, trunc_d;
   logic             pkt_end_q, pkt_end_d;
   logic             err_q, err_d;
   logic [31:0]      awaddr_q, awaddr_d;
   logic [7:0]       awlen_q, awlen_d;
   logic [7:0]       beat_q, beat_d;

   logic [35:0]      fifo_rdata;
   logic             fifo_full, fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic             active, accept, drop, push, pop;
   logic [2:0]       beat_bytes;
   logic [11:0]      cnt_ext, beats_to_4k, burst_len;
   logic             burst_go;

   s2mm_fifo #(.WIDTH(36), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({s_axis.tkeep, s_axis.tdata}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Burst sizing: never more than buffered, MAX_BURST, or the beats left before the 4 KB line.
   always_comb begin
      cnt_ext     = 12'(fifo_count);
      beats_to_4k = 12'((13'(BOUNDARY_4K) - {1'b0, addr_q[11:0]}) >> 2);
      burst_len   = cnt_ext;
      if (burst_len > 12'(MAX_BURST)) burst_len = 12'(MAX_BURST);
      if (burst_len > beats_to_4k)    burst_len = beats_to_4k;
      burst_go = (cnt_ext >= 12'(MAX_BURST)) || (cnt_ext >= beats_to_4k) ||
                 (pkt_end_q && !fifo_empty);
   end

   always_comb begin
      active     = (state_q != S_IDLE) && (state_q != S_DONE);
      beat_bytes = keep_bytes(s_axis.tkeep);
      accept     = s_axis.tvalid && s_axis.tready;
      // once truncated, every remaining beat of the packet is swallowed
      drop       = trunc_q ||
                   (({1'b0, acc_q} + (LEN_W+1)'(beat_bytes)) > {1'b0, max_q});
      push       = accept && !drop;
      pop        = m_axi.wvalid && m_axi.wready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (cmd_valid) state_d = S_FILL;
         S_FILL: begin
            if (burst_go)       state_d = S_ADDR;
            else if (pkt_end_q) state_d = S_DONE;
         end
         S_ADDR: if (m_axi.awready) state_d = S_DATA;
         S_DATA: if (pop && m_axi.wlast) state_d = S_RESP;
         S_RESP: if (m_axi.bvalid) state_d = (pkt_end_q && fifo_empty) ? S_DONE : S_FILL;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready     = (state_q == S_IDLE);
      s_axis.tready = active && !pkt_end_q && (trunc_q || !fifo_full);
      m_axi.awvalid = (state_q == S_ADDR);
      m_axi.awaddr  = awaddr_q;
      m_axi.awlen   = awlen_q;
      m_axi.wvalid  = (state_q == S_DATA) && !fifo_empty;
      m_axi.wdata   = fifo_rdata[31:0];
      m_axi.wstrb   = fifo_rdata[35:32];
      m_axi.wlast   = (state_q == S_DATA) && (beat_q == awlen_q);
      m_axi.bready  = (state_q == S_RESP);
      sts_valid     = (state_q == S_DONE);
      sts_bytes     = bytes_q;
      sts_trunc     = trunc_q;
      sts_error     = err_q;
   end

   always_comb begin
      addr_d    = addr_q;
      max_d     = max_q;
      acc_d     = acc_q;
      bytes_d   = bytes_q;
      trunc_d   = trunc_q;
      pkt_end_d = pkt_end_q;
      err_d     = err_q;
      awaddr_d  = awaddr_q;
      awlen_d   = awlen_q;
      beat_d    = beat_q;
      if (state_q == S_IDLE) begin
         pkt_end_d = 1'b0;
         if (cmd_valid) begin
            addr_d  = cmd_addr & ~32'h3;
            max_d   = cmd_max_bytes;
            acc_d   = '0;
            bytes_d = '0;
            trunc_d = 1'b0;
            err_d   = 1'b0;
         end
      end
      if (accept) begin
         if (drop) trunc_d = 1'b1;
         else      acc_d   = acc_q + LEN_W'(beat_bytes);
         if (s_axis.tlast) pkt_end_d = 1'b1;
      end
      if ((state_q == S_FILL) && burst_go) begin
         awaddr_d = addr_q;
         awlen_d  = 8'(burst_len - 12'd1);
         beat_d   = '0;
      end
      if (pop) begin
         beat_d  = beat_q + 8'd1;
         bytes_d = bytes_q + LEN_W'(keep_bytes(m_axi.wstrb));
      end
      if ((state_q == S_RESP) && m_axi.bvalid) begin
         addr_d = addr_q + (32'(awlen_q) + 32'd1) * 32'(BYTES_PER_BEAT);
         if ((m_axi.bresp == AXI_RESP_SLVERR) || (m_axi.bresp == AXI_RESP_DECERR)) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q    <= '0;
         max_q     <= '0;
         acc_q     <= '0;
         bytes_q   <= '0;
         trunc_q   <= 1'b0;
         pkt_end_q <= 1'b0;
         err_q     <= 1'b0;
         awaddr_q  <= '0;
         awlen_q   <= '0;
         beat_q    <= '0;
      end else begin
         addr_q    <= addr_d;
         max_q     <= max_d;
         acc_q     <= acc_d;
         bytes_q   <= bytes_d;
         trunc_q   <= trunc_d;
         pkt_end_q <= pkt_end_d;
         err_q     <= err_d;
         awaddr_q  <= awaddr_d;
         awlen_q   <= awlen_d;
         beat_q    <= beat_d;
      end
   end

endmodule

// File: tb/tb_s2mm_top.sv
// tb/tb_s2mm_top.sv - directed self-checking bench for s2mm_top with a stalling AXI write slave
module tb_s2mm_top;
   import dma_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_addr = '0;
   logic [15:0] cmd_max_bytes = '0;
   logic        sts_valid;
   logic [15:0] sts_bytes;
   logic        sts_trunc;
   logic        sts_error;

   axis_if   s_axis ();
   axi_wr_if m_axi ();

   s2mm_top #(.MAX_BURST(16), .FIFO_DEPTH(32), .LEN_W(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_addr      (cmd_addr),
      .cmd_max_bytes (cmd_max_bytes),
      .sts_valid     (sts_valid),
      .sts_bytes     (sts_bytes),
      .sts_trunc     (sts_trunc),
      .sts_error     (sts_error),
      .s_axis        (s_axis),
      .m_axi         (m_axi)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] aw_addr [$];
   logic [7:0]  aw_len [$];
   logic [31:0] w_data [$];
   logic [3:0]  w_strb [$];
   logic        w_last [$];
   logic        sts_seen = 1'b0;
   logic [15:0] cap_bytes = '0;
   logic        cap_trunc = 1'b0;
   logic        cap_err = 1'b0;
   logic        stall = 1'b0;
   logic        abort = 1'b0;
   logic        b_fire = 1'b0;
   logic [1:0]  bresp_val = AXI_RESP_OKAY;
   int          pending = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // AXI write slave and status monitor: drive after negedge, sample 1 ns later
   initial begin
      m_axi.awready = 1'b0;
      m_axi.wready  = 1'b0;
      m_axi.bvalid  = 1'b0;
      m_axi.bresp   = AXI_RESP_OKAY;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pending = 0;
            b_fire = 1'b0;
            m_axi.bvalid = 1'b0;
            m_axi.awready = 1'b0;
            m_axi.wready = 1'b0;
         end else begin
            if (b_fire) begin
               m_axi.bvalid = 1'b0;
               b_fire = 1'b0;
            end
            m_axi.awready = !stall || ($urandom_range(0, 2) != 0);
            m_axi.wready  = !stall || ($urandom_range(0, 2) != 0);
            if (!m_axi.bvalid)
               m_axi.bvalid = (pending > 0) && (!stall || ($urandom_range(0, 1) == 1));
            m_axi.bresp = bresp_val;
            #1;
            if (m_axi.awvalid && m_axi.awready) begin
               aw_addr.push_back(m_axi.awaddr);
               aw_len.push_back(m_axi.awlen);
            end
            if (m_axi.wvalid && m_axi.wready) begin
               w_data.push_back(m_axi.wdata);
               w_strb.push_back(m_axi.wstrb);
               w_last.push_back(m_axi.wlast);
               if (m_axi.wlast) pending++;
            end
            if (m_axi.bvalid && m_axi.bready) begin
               pending--;
               b_fire = 1'b1;
            end
            if (sts_valid) begin
               sts_seen  = 1'b1;
               cap_bytes = sts_bytes;
               cap_trunc = sts_trunc;
               cap_err   = sts_error;
            end
         end
      end
   end

   task automatic issue_cmd(input logic [31:0] addr, input logic [15:0] maxb);
      int guard;
      aw_addr.delete(); aw_len.delete();
      w_data.delete(); w_strb.delete(); w_last.delete();
      sts_seen = 1'b0;
      @(negedge clk);
      cmd_addr = addr;
      cmd_max_bytes = maxb;
      cmd_valid = 1'b1;
      #1;
      guard = 0;
      while (!cmd_ready && guard < 1000) begin
         @(negedge clk); #1; guard++;
      end
      if (guard >= 1000) check("cmd_ready_timeout", 0, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic send_pkt(input int n, input logic [3:0] last_keep, input logic [31:0] base);
      int guard;
      for (int i = 0; i < n && !abort; i++) begin
         @(negedge clk);
         while (stall && $urandom_range(0, 3) == 0) begin
            s_axis.tvalid = 1'b0;
            @(negedge clk);
         end
         s_axis.tvalid = 1'b1;
         s_axis.tdata  = base + 32'(i);
         s_axis.tkeep  = (i == n - 1) ? last_keep : 4'hF;
         s_axis.tlast  = (i == n - 1);
         #1;
         guard = 0;
         while (!s_axis.tready && guard < 3000 && !abort) begin
            @(negedge clk); #1; guard++;
         end
         if (guard >= 3000) check("tready_timeout", 0, 1);
      end
      @(negedge clk);
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
   endtask

   task automatic wait_sts();
      int guard = 0;
      while (!sts_seen && guard < 5000) begin
         @(negedge clk); guard++;
      end
      #2;
      check("sts_valid_seen", sts_seen, 1);
   endtask

   task automatic run_cmd(input logic [31:0] addr, input logic [15:0] maxb, input int n,
                          input logic [3:0] last_keep, input logic [31:0] base);
      issue_cmd(addr, maxb);
      send_pkt(n, last_keep, base);
      wait_sts();
   endtask

   task automatic check_run(input string tag, input int nb, input logic [31:0] ea [3],
                            input int el [3], input int nw, input logic [31:0] base,
                            input logic [3:0] last_strb, input int eb, input logic etr,
                            input logic eer);
      int k = 0;
      check({tag, "_nbursts"}, aw_addr.size(), nb);
      for (int b = 0; b < nb; b++) begin
         check($sformatf("%s_awaddr%0d", tag, b), aw_addr[b], ea[b]);
         check($sformatf("%s_awlen%0d", tag, b), aw_len[b], el[b]);
         for (int j = 0; j <= el[b]; j++) begin
            check($sformatf("%s_wlast%0d_%0d", tag, b, j), w_last[k], (j == el[b]));
            k++;
         end
      end
      check({tag, "_nbeats"}, w_data.size(), nw);
      for (int i = 0; i < nw; i++) begin
         check($sformatf("%s_wdata%0d", tag, i), w_data[i], base + 32'(i));
         check($sformatf("%s_wstrb%0d", tag, i), w_strb[i], (i == nw - 1) ? last_strb : 4'hF);
      end
      check({tag, "_sts_bytes"}, cap_bytes, eb);
      check({tag, "_sts_trunc"}, cap_trunc, etr);
      check({tag, "_sts_error"}, cap_err, eer);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      s_axis.tvalid = 1'b0;
      s_axis.tdata  = '0;
      s_axis.tkeep  = '0;
      s_axis.tlast  = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk); #1;
      check("rst_outputs", {m_axi.awvalid, m_axi.wvalid, m_axi.wlast, m_axi.bready,
                            sts_valid, sts_trunc, sts_error, s_axis.tready}, 0);
      check("rst_awaddr", m_axi.awaddr, 0);
      check("rst_awlen", m_axi.awlen, 0);
      check("rst_sts_bytes", sts_bytes, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      check("idle_cmd_ready", cmd_ready, 1);

      run_cmd(32'h1000, 16'd256, 8, 4'hF, 32'hA000_0000);
      check_run("t1_single", 1, '{32'h1000, 0, 0}, '{7, 0, 0}, 8, 32'hA000_0000, 4'hF, 32, 0, 0);

      stall = 1'b1;
      run_cmd(32'h1000, 16'd256, 40, 4'hF, 32'hB000_0000);
      check_run("t2_split", 3, '{32'h1000, 32'h1040, 32'h1080}, '{15, 15, 7}, 40,
                32'hB000_0000, 4'hF, 160, 0, 0);

      run_cmd(32'h1FF8, 16'd256, 6, 4'hF, 32'hC000_0000);
      check_run("t3_4k", 2, '{32'h1FF8, 32'h2000, 0}, '{1, 3, 0}, 6, 32'hC000_0000, 4'hF,
                24, 0, 0);

      run_cmd(32'h3000, 16'd10, 5, 4'hF, 32'hD000_0000);
      check_run("t4_trunc", 1, '{32'h3000, 0, 0}, '{1, 0, 0}, 2, 32'hD000_0000, 4'hF, 8, 1, 0);

      bresp_val = AXI_RESP_SLVERR;
      run_cmd(32'h4000, 16'd256, 3, 4'h3, 32'hE000_0000);
      check_run("t5_partial_err", 1, '{32'h4000, 0, 0}, '{2, 0, 0}, 3, 32'hE000_0000, 4'h3,
                10, 0, 1);
      bresp_val = AXI_RESP_OKAY;

      run_cmd(32'h6000, 16'd0, 3, 4'hF, 32'hF000_0000);
      check_run("t6_max0", 0, '{0, 0, 0}, '{0, 0, 0}, 0, 32'hF000_0000, 4'hF, 0, 1, 0);

      abort = 1'b0;
      fork
         begin
            issue_cmd(32'h1000, 16'd256);
            send_pkt(40, 4'hF, 32'h1111_0000);
         end
         begin
            guard = 0;
            while (m_axi.wvalid !== 1'b1 && guard < 3000) begin
               @(negedge clk); #1; guard++;
            end
            check("rst_mid_reached_data", guard < 3000, 1);
            abort = 1'b1;
            #1 rst_n = 1'b0;
            #1;
            check("rst_mid_outputs", {m_axi.awvalid, m_axi.wvalid, m_axi.wlast, m_axi.bready,
                                      sts_valid, sts_trunc, sts_error, s_axis.tready}, 0);
            check("rst_mid_awaddr", m_axi.awaddr, 0);
            check("rst_mid_sts_bytes", sts_bytes, 0);
         end
      join
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      abort = 1'b0;

      run_cmd(32'h5002, 16'd256, 4, 4'hF, 32'h2222_0000);
      check_run("t7_after_rst", 1, '{32'h5000, 0, 0}, '{3, 0, 0}, 4, 32'h2222_0000, 4'hF,
                16, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
